// File: rtl/hybrid_adder_pkg.sv
// Shared types and helpers for the pipelined hybrid approximate adder/subtractor.
package hybrid_adder_pkg;

  localparam int ERR_CNT_W = 16;

  // Per-beat operation mode travelling with the operands.
  typedef struct packed {
    logic sub;
    logic exact;
  } mode_t;

  // The LOA predicts the carry out of the lower segment from its top bit pair only.
  function automatic logic loa_carry(input logic a_msb, input logic b_msb);
    return a_msb & b_msb;
  endfunction

endpackage

// File: rtl/pipelined_hybrid_addsub_loa_segment.sv
// Combinational NA-bit lower segment: exact ripple add or lower-part OR adder (LOA).
module loa_segment
  import hybrid_adder_pkg::*;
#(
  parameter int NA = 16
) (
  input  logic [NA-1:0] a,
  input  logic [NA-1:0] b,
  input  logic          cin,
  input  logic          exact,
  output logic [NA-1:0] lo,
  output logic          fn
);

  logic [NA:0] exact_sum;

  assign exact_sum = {1'b0, a} + {1'b0, b} + {{NA{1'b0}}, cin};

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    lo = exact_sum[NA-1:0];
    fn = exact_sum[NA];
    if (!exact) begin
      // Approximate mode drops cin entirely; the carry is predicted, not propagated.
      lo = a | b;
      fn = loa_carry(a[NA-1], b[NA-1]);
    end
  end

endmodule

// File: rtl/pipelined_hybrid_addsub.sv
// Two-stage hybrid approximate adder/subtractor with valid/ready on both sides.
// Optional HYBRID_ERR_MONITOR_EN adds an exact shadow path and a saturating error counter.
module pipelined_hybrid_addsub
  import hybrid_adder_pkg::*;
#(
  parameter int N  = 32,
  parameter int NA = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_exact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
`ifdef HYBRID_ERR_MONITOR_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
`endif
);

  localparam int NH = N - NA;

  mode_t         mode;
  logic [N-1:0]  bx;
  logic [NA-1:0] lo_d;
  logic          fn_d;
  logic          s1_adv, s2_adv;

  logic          s1_valid_q, s2_valid_q;
  logic [NA-1:0] s1_lo_q;
  logic          s1_fn_q;
  logic [NH-1:0] s1_a_hi_q, s1_bx_hi_q;
  logic [N-1:0]  sum_q;
  logic          cout_q, ovf_q;

  logic [NH:0]   hi_sum;
  logic [N-1:0]  sum_d;
  logic          ovf_d;

  assign mode = '{sub: in_sub, exact: in_exact};
  assign bx   = mode.sub ? ~in_b : in_b;

  // Backpressure ripples combinationally from out_ready; there is no skid buffer.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  loa_segment #(.NA(NA)) u_loa (
    .a     (in_a[NA-1:0]),
    .b     (bx[NA-1:0]),
    .cin   (mode.sub),
    .exact (mode.exact),
    .lo    (lo_d),
    .fn    (fn_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_fn_q    <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_bx_hi_q <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_lo_q    <= lo_d;
        s1_fn_q    <= fn_d;
        s1_a_hi_q  <= in_a[N-1:NA];
        s1_bx_hi_q <= bx[N-1:NA];
      end
    end
  end

  assign hi_sum = {1'b0, s1_a_hi_q} + {1'b0, s1_bx_hi_q} + {{NH{1'b0}}, s1_fn_q};
  assign sum_d  = {hi_sum[NH-1:0], s1_lo_q};
  assign ovf_d  = (s1_a_hi_q[NH-1] == s1_bx_hi_q[NH-1]) && (sum_d[N-1] != s1_a_hi_q[NH-1]);

  // NOTE: result registers are reset because the reset value of out_sum is observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= hi_sum[NH];
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

`ifdef HYBRID_ERR_MONITOR_EN
  logic [N-1:0]         ref_d, s1_ref_q, s2_ref_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign ref_d = in_a + bx + {{(N-1){1'b0}}, in_sub};

  // Shadow result shares the stage enables so it stays aligned with its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ref_q <= '0;
      s2_ref_q <= '0;
    end else begin
      if (s1_adv && in_valid) s1_ref_q <= ref_d;
      if (s2_adv && s1_valid_q) s2_ref_q <= s1_ref_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_clr) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && (sum_q != s2_ref_q) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_hybrid_addsub.sv
// Self-checking bench: directed vectors, a queue-based reference model and a per-cycle compare.
module tb_pipelined_hybrid_addsub;

  localparam int N  = 32;
  localparam int NA = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a, in_b;
  logic         in_sub, in_exact;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout, out_ovf;
`ifdef HYBRID_ERR_MONITOR_EN
  logic [15:0]  err_cnt;
  logic         err_clr;
  int           err_model;
`endif

  always #5 clk = ~clk;

  pipelined_hybrid_addsub #(.N(N), .NA(NA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
`ifdef HYBRID_ERR_MONITOR_EN
    ,
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
`endif
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         exact;
    bit           has_lit;
    logic [N-1:0] lit_sum;
    logic         lit_cout;
    logic         lit_ovf;
    int           acc_cyc;
  } beat_t;

  beat_t q[$];
  beat_t cur;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    cons_cnt = 0;
  bit    in_rst = 1'b1;
  bit    last_acc = 1'b0;
  bit    rdy_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact mode is a plain full-width add; approx mode ORs the low part and
  // feeds the top-pair AND into the upper add.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sub, input logic exact);
    logic [N-1:0]    bx;
    logic [N:0]      full;
    logic [N-NA:0]   hi;
    logic            fn;
    logic            ovf;
    bx = sub ? ~b : b;
    if (exact) begin
      full = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, sub};
    end else begin
      fn   = a[NA-1] & bx[NA-1];
      hi   = {1'b0, a[N-1:NA]} + {1'b0, bx[N-1:NA]} + {{(N-NA){1'b0}}, fn};
      full = {hi, a[NA-1:0] | bx[NA-1:0]};
    end
    ovf = (a[N-1] == bx[N-1]) && (full[N-1] != a[N-1]);
    return {ovf, full};
  endfunction

  // Compare process: runs on every falling edge, checks handshake and data against the model.
  initial begin
    logic [N+1:0] m, r;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        last_acc = 1'b0;
      end else begin
        check("in_ready", in_ready, (q.size() < 2) || out_ready);
        check("out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].acc_cyc + 2));
`ifdef HYBRID_ERR_MONITOR_EN
        check("err_cnt", err_cnt, err_model);
`endif
        if (out_valid && q.size() > 0) begin
          m = model(q[0].a, q[0].b, q[0].sub, q[0].exact);
          check("out_sum", out_sum, m[N-1:0]);
          check("out_cout", out_cout, m[N]);
          check("out_ovf", out_ovf, m[N+1]);
          if (q[0].has_lit && out_ready) begin
            check("lit_sum", out_sum, q[0].lit_sum);
            check("lit_cout", out_cout, q[0].lit_cout);
            check("lit_ovf", out_ovf, q[0].lit_ovf);
          end
        end
`ifdef HYBRID_ERR_MONITOR_EN
        if (err_clr) err_model = 0;
        else if (out_valid && out_ready && q.size() > 0) begin
          r = model(q[0].a, q[0].b, q[0].sub, 1'b1);
          if (m[N-1:0] != r[N-1:0] && err_model != 16'hFFFF) err_model++;
        end
`endif
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          cons_cnt++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
          beat_t e;
          e = cur;
          e.acc_cyc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? rdy_pat[cyc % 4] : 1'b1;
    end
  end

  task automatic send(input beat_t b);
    int budget;
    budget = 0;
    cur      = b;
    in_a     = b.a;
    in_b     = b.b;
    in_sub   = b.sub;
    in_exact = b.exact;
    in_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (!last_acc && budget < 100);
    if (!last_acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_lit(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                          input logic exact, input logic [N-1:0] s, input logic c, input logic o);
    beat_t v;
    v = '{a: a, b: b, sub: sub, exact: exact, has_lit: 1'b1,
          lit_sum: s, lit_cout: c, lit_ovf: o, acc_cyc: 0};
    send(v);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int start_cnt;
    beat_t v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_exact  = 1'b0;
    out_ready = 1'b1;
`ifdef HYBRID_ERR_MONITOR_EN
    err_clr   = 1'b0;
    err_model = 0;
`endif
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 in_rst = 1'b0;

    // Directed vectors with hand-computed results.
    send_lit(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
    send_lit(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    send_lit(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 32'h0001_8000, 1'b0, 1'b0);
    send_lit(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0);
    send_lit(32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_lit(32'd7,         32'd5,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    send_lit(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    send_lit(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0);
    send_lit(32'd7,         32'd5,         1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_lit(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    drain();
    check("directed_count", cons_cnt, 10);

`ifdef HYBRID_ERR_MONITOR_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
`endif

    // Backpressure: 8 back-to-back mixed-mode beats, out_ready toggling 1,0,0,1.
    rdy_mode  = 1'b1;
    start_cnt = cons_cnt;
    for (int i = 0; i < 8; i++) begin
      v = '{a: $urandom, b: $urandom, sub: 1'($urandom), exact: 1'(i % 2),
            has_lit: 1'b0, lit_sum: '0, lit_cout: 1'b0, lit_ovf: 1'b0, acc_cyc: 0};
      send(v);
    end
    drain();
    check("bp_count", cons_cnt - start_cnt, 8);
    rdy_mode = 1'b0;
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    send_lit(32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
    send_lit(32'd3, 32'd4, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
    in_rst = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    check("mid_rst_out_cout", out_cout, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    q.delete();
`ifdef HYBRID_ERR_MONITOR_EN
    check("mid_rst_err_cnt", err_cnt, 0);
    err_model = 0;
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 in_rst = 1'b0;
    start_cnt = cons_cnt;
    send_lit(32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    drain();
    check("post_rst_count", cons_cnt - start_cnt, 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
